// File: rtl/kb_pkg.sv
// Shared types and constants for the keyboard character FIFO.
// Capture FSM encoding, carriage-return code and printable-flag position.
package kb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TAKE   = 3'd2,
    ST_ACK    = 3'd3,
    ST_DRAIN  = 3'd4
  } kb_state_e;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam int         PRINT_BIT = 15;

  function automatic logic is_cr(input logic [7:0] c);
    return c == ASCII_CR;
  endfunction

endpackage

// File: rtl/kb_sync_fifo.sv
// Synchronous show-ahead character FIFO.
// Full is judged before a same-cycle pop, so a write into a full FIFO is refused.
module kb_sync_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          wr_ok,
  output logic          rd_ok,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  always_comb begin
    wr_ok    = wr_en & ~full_q;
    rd_ok    = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    full_d   = count_d == CW'(DEPTH);
    empty_d  = count_d == '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;

endmodule

// File: rtl/kb_char_fifo.sv
// Keyboard decoder capture front-end feeding a character FIFO.
// Each pending decoder code is sampled once, acknowledged with kb_rdn, then drained.
module kb_char_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kb_ready,
  input  logic [15:0]   kb_ascii,
  output logic          kb_rdn,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic [CW-1:0] line_cnt,
  output logic          overflow
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  kb_state_e     state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] line_q, line_d;
  logic          overflow_q, overflow_d;
  logic          wr_req;
  logic          wr_ok;
  logic          rd_ok;
  logic          unused_hi;

  assign unused_hi = ^kb_ascii[14:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (kb_ready) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!kb_ready)
          state_d = ST_IDLE;
        else if (settle_q == SW'(SETTLE - 1))
          state_d = ST_TAKE;
        else
          settle_d = settle_q + 1'b1;
      end
      ST_TAKE:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_DRAIN;
      ST_DRAIN: if (!kb_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    kb_rdn = state_q != ST_ACK;
    wr_req = (state_q == ST_TAKE)
           & kb_ascii[PRINT_BIT]
           & (|kb_ascii[7:0]);
  end

  kb_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_req),
    .wr_data(kb_ascii[7:0]),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .wr_ok  (wr_ok),
    .rd_ok  (rd_ok),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  // A CR written and popped in the same cycle cancels out.
  always_comb begin
    overflow_d = overflow_q | (wr_req & full);
    line_d     = line_q
               + CW'(wr_ok & is_cr(kb_ascii[7:0]))
               - CW'(rd_ok & is_cr(rd_data));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      line_q     <= line_d;
      overflow_q <= overflow_d;
    end
  end

  assign line_cnt = line_q;
  assign overflow = overflow_q;

endmodule

// File: doc/kb_char_fifo.md
KB_CHAR_FIFO -- requirements
Module: kb_char_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4 to 64.
REQ-002 Parameter SETTLE, default 2, clk cycles after kb_ready rises before kb_ascii is valid.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 kb_ready  input  1  keyboard decoder has a code pending.
REQ-006 kb_ascii  input  16  decoder word; bit15 = printable flag, bits7:0 = ASCII.
REQ-007 kb_rdn  output  1  active-low read strobe back to the decoder; clears kb_ready.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 rd_data  output  8  head-of-FIFO character, valid while empty=0.
REQ-010 empty  output  1  FIFO holds no entries.
REQ-011 full  output  1  FIFO holds DEPTH entries.
REQ-012 count  output  log2(DEPTH)+1  current occupancy.
REQ-013 line_cnt  output  log2(DEPTH)+1  number of 0x0D characters currently stored.
REQ-014 overflow  output  1  sticky; a character was dropped because the FIFO was full.

Function
REQ-015 Capture FSM states IDLE, SETTLE, TAKE, ACK, DRAIN.
REQ-016 IDLE -> SETTLE when kb_ready=1; settle counter loads 0.
REQ-017 SETTLE counts SETTLE cycles, then -> TAKE; kb_ready falling during SETTLE -> IDLE with nothing written.
REQ-018 TAKE samples kb_ascii for one cycle: bit15=1 and bits7:0 != 0 is a write request; anything else is discarded. Always -> ACK.
REQ-019 ACK drives kb_rdn=0 for exactly one cycle, -> DRAIN.
REQ-020 DRAIN holds kb_rdn=1 until kb_ready=0, then -> IDLE, so each decoder code is captured at most once.
REQ-021 kb_rdn=1 in every state except ACK.
REQ-022 Write request with full=1: no write; overflow set to 1 and held until rst.
REQ-023 Pop: rd_en=1 with empty=0 advances the head next cycle; rd_en with empty=1 is ignored; no underflow flag.
REQ-024 rd_data is combinational from the head entry (zero-latency show-ahead); contents are undefined when empty=1.
REQ-025 A write is visible on rd_data/empty the cycle after TAKE.
REQ-026 Simultaneous write and pop: both take effect; count unchanged. When full, the write is still rejected (full is evaluated before the pop).
REQ-027 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count = writes - pops.
REQ-028 line_cnt increments on write of 0x0D and decrements on pop of 0x0D; a simultaneous write and pop of 0x0D leaves it unchanged.
REQ-029 full, empty and count are registered and consistent every cycle.

Reset
REQ-030 rst clears the pointers, count and line_cnt to 0, sets empty=1, full=0, overflow=0 and kb_rdn=1, and returns the FSM to IDLE.
REQ-031 rst during SETTLE, TAKE, ACK or DRAIN aborts the capture with no write; a kb_ready still high after reset starts a new capture.
REQ-032 FIFO storage contents are not reset.

Structure
REQ-033 Shared package kb_pkg holds the FSM state encoding, the ASCII_CR=8'h0D constant and the printable-flag bit index (15).
REQ-034 One sub-module, kb_sync_fifo, holds the storage, pointers, count, full and empty; the capture FSM and line_cnt stay at top level.

Verification
REQ-035 kb_ready rises with kb_ascii=16'h8061 from the third cycle -> one write, rd_data=8'h61; kb_rdn low exactly one cycle; count=1.
REQ-036 kb_ready held high for 20 cycles with a printable code -> exactly one write; FSM stays in DRAIN until kb_ready falls.
REQ-037 kb_ascii=16'h0000 (break prefix) -> no write, kb_rdn pulse still issued, count unchanged.
REQ-038 17 writes with no pops -> full=1 after the 16th, 17th dropped, overflow=1; 16 pops then return the original order, ending with empty=1.
REQ-039 Write 0x0D while popping 0x0D in the same cycle -> line_cnt and count unchanged; DEPTH+3 write/pop pairs verify pointer wrap.
REQ-040 rst asserted in SETTLE -> no write, kb_rdn=1, all outputs at reset values next cycle.
